// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: handshake and data bundle between execute, ex_mem_stage and memory/writeback
// Upstream side: flush, in_valid/in_ready, ALU result/zero, store data, pc, imm, rd and controls.
// Downstream side: out_valid/out_ready, head entry fields, and the branch redirect to fetch.
// slave is the stage itself; master is whoever drives the stage inputs.
interface ex_mem_stage_if #(
  parameter int XLEN = 64,
  parameter int RegAddrW = 5
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     alu_result;
  logic                alu_zero;
  logic [XLEN-1:0]     rs2_data;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     imm;
  logic [RegAddrW-1:0] rd;
  logic                Branch;
  logic                BranchNe;
  logic                MemRead;
  logic                MemWrite;
  logic                RegWrite;
  logic                MemtoReg;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [XLEN-1:0]     out_store_data;
  logic [RegAddrW-1:0] out_rd;
  logic                out_MemRead;
  logic                out_MemWrite;
  logic                out_RegWrite;
  logic                out_MemtoReg;
  logic                branch_taken;
  logic [XLEN-1:0]     branch_target;
  modport slave (
    input  flush, in_valid, alu_result, alu_zero, rs2_data, pc, imm, rd,
           Branch, BranchNe, MemRead, MemWrite, RegWrite, MemtoReg, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd,
           out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg,
           branch_taken, branch_target
  );
  modport master (
    output flush, in_valid, alu_result, alu_zero, rs2_data, pc, imm, rd,
           Branch, BranchNe, MemRead, MemWrite, RegWrite, MemtoReg, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd,
           out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg,
           branch_taken, branch_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: two-entry skid buffer between execute and memory with branch resolution
// Ports: clk (rising edge), reset (async, active-high), bus (ex_mem_stage_if.slave) carrying
// the upstream valid/ready entry, the downstream head entry and the one-cycle branch redirect.
module ex_mem_stage #(
  parameter int XLEN = 64,
  parameter int RegAddrW = 5
) (
  input logic clk,
  input logic reset,
  ex_mem_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [XLEN-1:0]     store_data;
    logic [RegAddrW-1:0] rd;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t          state_q, state_d;
  entry_t          head_q, head_d, skid_q, skid_d, in_e;
  logic            in_ready_q, in_ready_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            accept, pop;
  assign accept = bus.in_valid && in_ready_q;
  assign pop    = (state_q != EMPTY) && bus.out_ready;
  always_comb begin
    in_e = '{result: bus.alu_result, store_data: bus.rs2_data, rd: bus.rd,
             mem_read: bus.MemRead, mem_write: bus.MemWrite,
             reg_write: bus.RegWrite, mem_to_reg: bus.MemtoReg};
    state_d  = state_q;
    head_d   = head_q;
    skid_d   = skid_q;
    taken_d  = 1'b0;
    target_d = target_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_d  = in_e;
          state_d = ONE;
        end
        ONE: if (accept && pop) begin
          head_d = in_e;
        end else if (accept) begin
          skid_d  = in_e;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
        FULL: if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
      taken_d  = accept && bus.Branch && (bus.alu_zero ^ bus.BranchNe);
      target_d = accept ? bus.pc + (bus.imm << 1) : target_q;
    end
    // in_ready is registered from the next state so it never depends on out_ready combinationally
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      taken_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
    end
  end
  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = state_q != EMPTY;
  assign bus.out_result     = head_q.result;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_MemRead    = head_q.mem_read;
  assign bus.out_MemWrite   = head_q.mem_write;
  assign bus.out_RegWrite   = head_q.reg_write;
  assign bus.out_MemtoReg   = head_q.mem_to_reg;
  assign bus.branch_taken   = taken_q;
  assign bus.branch_target  = target_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random checks of ex_mem_stage against a queue-based model
module tb_ex_mem_stage;
  localparam int XLEN = 64;
  localparam int RW = 5;
  typedef struct packed {
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset;
  ent_t        q[$];
  logic        exp_taken = 1'b0;
  logic [63:0] exp_target = '0;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  ex_mem_stage_if #(.XLEN(XLEN), .RegAddrW(RW)) bus ();
  ex_mem_stage #(.XLEN(XLEN), .RegAddrW(RW)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic set_in(input logic v, input logic [63:0] res, input logic [4:0] r,
                        input logic br, input logic bne, input logic z,
                        input logic [63:0] p, input logic [63:0] im);
    bus.in_valid = v;
    bus.alu_result = res;
    bus.rd = r;
    bus.Branch = br;
    bus.BranchNe = bne;
    bus.alu_zero = z;
    bus.pc = p;
    bus.imm = im;
    bus.rs2_data = {$urandom, $urandom};
    {bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg} = 4'($urandom);
  endtask
  // One clock: update the reference model from the inputs seen at the edge, then compare.
  task automatic cycle();
    logic acc, pp;
    @(posedge clk);
    acc = bus.in_valid && (q.size() < 2);
    pp = (q.size() > 0) && bus.out_ready;
    if (bus.flush) begin
      q.delete();
      exp_taken = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{res: bus.alu_result, sd: bus.rs2_data, rd: bus.rd,
                            ctl: {bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg}});
      exp_taken = acc && bus.Branch && (bus.alu_zero != bus.BranchNe);
      if (exp_taken) exp_target = bus.pc + 64'(2) * bus.imm;
    end
    #1;
    chk1("out_valid", bus.out_valid, q.size() > 0);
    chk1("in_ready", bus.in_ready, q.size() < 2);
    chk1("branch_taken", bus.branch_taken, exp_taken);
    if (exp_taken) chk("branch_target", bus.branch_target, exp_target);
    if (q.size() > 0) begin
      chk("out_result", bus.out_result, q[0].res);
      chk("out_store_data", bus.out_store_data, q[0].sd);
      chk("out_rd_ctl", 64'({bus.out_rd, bus.out_MemRead, bus.out_MemWrite, bus.out_RegWrite, bus.out_MemtoReg}),
          64'({q[0].rd, q[0].ctl}));
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1, 64'h55, 5'd7, 1, 0, 1, 64'h0, 64'h0);
    #3;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_taken", bus.branch_taken, 1'b0);
    chk("rst_out_result", bus.out_result, 64'h0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk1("rst_hold_valid", bus.out_valid, 1'b0);
    chk1("rst_hold_taken", bus.branch_taken, 1'b0);
    reset = 1'b0;
    set_in(1, 64'h10, 5'd3, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    chk("first_result", bus.out_result, 64'h10);
    chk("first_rd", 64'(bus.out_rd), 64'd3);
    set_in(0, 64'h0, 5'd0, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 64'hA0 + 64'(i), 5'(i + 1), 0, 0, 0, 64'h0, 64'h0);
      cycle();
      if (i == 0) chk1("bp_ready_after_1", bus.in_ready, 1'b1);
      if (i == 1) chk1("bp_ready_after_2", bus.in_ready, 1'b0);
    end
    set_in(0, 64'h0, 5'd0, 0, 0, 0, 64'h0, 64'h0);
    chk("bp_head0_stable", bus.out_result, 64'hA0);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_head1", bus.out_result, 64'hA1);
    cycle();
    chk1("bp_drained", bus.out_valid, 1'b0);
    set_in(1, 64'h0, 5'd1, 1, 0, 1, 64'h100, 64'h8);
    cycle();
    chk1("beq_taken", bus.branch_taken, 1'b1);
    chk("beq_target", bus.branch_target, 64'h110);
    set_in(1, 64'h0, 5'd1, 1, 1, 1, 64'h100, 64'h8);
    cycle();
    chk1("bne_not_taken", bus.branch_taken, 1'b0);
    set_in(1, 64'h0, 5'd2, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
    cycle();
    chk1("wrap_taken", bus.branch_taken, 1'b1);
    chk("wrap_target", bus.branch_target, 64'h10);
    set_in(1, 64'h0, 5'd2, 1, 1, 0, 64'h200, 64'h4);
    cycle();
    chk1("back_to_back_taken", bus.branch_taken, 1'b1);
    chk("back_to_back_target", bus.branch_target, 64'h208);
    bus.out_ready = 1'b0;
    set_in(1, 64'hB0, 5'd4, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    cycle();
    cycle();
    chk1("full_ready", bus.in_ready, 1'b0);
    set_in(1, 64'hB1, 5'd5, 1, 0, 1, 64'h300, 64'h8);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk1("flush_full_valid", bus.out_valid, 1'b0);
    chk1("flush_full_ready", bus.in_ready, 1'b1);
    chk1("flush_full_taken", bus.branch_taken, 1'b0);
    set_in(1, 64'hB2, 5'd6, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    set_in(1, 64'hB3, 5'd7, 1, 0, 1, 64'h400, 64'h8);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk1("flush_one_taken", bus.branch_taken, 1'b0);
    chk1("flush_one_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_in(1, 64'hC00 + 64'(i), 5'(i), 0, 0, 0, 64'h0, 64'h0);
      cycle();
      chk("stream_head", bus.out_result, 64'hC00 + 64'(i));
    end
    for (int i = 0; i < 600; i++) begin
      bus.flush = ($urandom % 20) == 0;
      bus.out_ready = 1'($urandom);
      set_in(($urandom % 4) != 0, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      cycle();
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1, 64'hD0, 5'd9, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    cycle();
    #3;
    reset = 1'b1;
    #1;
    chk1("async_rst_valid", bus.out_valid, 1'b0);
    chk1("async_rst_ready", bus.in_ready, 1'b1);
    chk("async_rst_result", bus.out_result, 64'h0);
    q.delete();
    exp_taken = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1, 64'hE0, 5'd10, 0, 0, 0, 64'h0, 64'h0);
    cycle();
    chk("post_rst_result", bus.out_result, 64'hE0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
